// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM deposit accumulator.
// Holds the FSM state encoding, the money width and the default session limits.
package atm_pkg;

  localparam int MONEY_W = 16;
  localparam int AMT_W   = 8;
  localparam int CNT_W   = 4;

  localparam int                 DEF_STABLE_CYCLES = 4;
  localparam logic [MONEY_W-1:0] DEF_MAX_TOTAL     = 16'd9999;
  localparam logic [AMT_W-1:0]   DEF_MAX_BILLS     = 8'd50;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    WAIT_REL = 2'd2,
    SETTLE   = 2'd3
  } state_t;

endpackage

// File: rtl/atm_bill_qualifier.sv
// Capture register and stability counter for incoming bill values.
// The top FSM decides when to load, advance or clear; this block holds the state.
module atm_bill_qualifier
  import atm_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  input  logic             clr,
  input  logic [AMT_W-1:0] amount,
  output logic [AMT_W-1:0] cap,
  output logic [CNT_W-1:0] cnt,
  output logic             same,
  output logic             ripe
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap <= '0;
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cap <= amount;
      cnt <= CNT_W'(1);
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign same = (amount == cap);
  // The next matching sample is the one that completes qualification.
  assign ripe = (cnt == LAST);

endmodule

// File: rtl/atm_deposit_accumulator.sv
// Session accumulator for an ATM bill acceptor: qualifies bills, enforces limits,
// and commits or refunds the running total on confirm/cancel.
module atm_deposit_accumulator
  import atm_pkg::*;
#(
  parameter int                 STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic [MONEY_W-1:0] MAX_TOTAL     = DEF_MAX_TOTAL,
  parameter logic [AMT_W-1:0]   MAX_BILLS     = DEF_MAX_BILLS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AMT_W-1:0]   amount,
  input  logic               multi_err,
  input  logic               confirm,
  input  logic               cancel,
  output logic [MONEY_W-1:0] total,
  output logic [AMT_W-1:0]   bill_count,
  output logic               accept,
  output logic               reject,
  output logic               deposit_done,
  output logic               refund,
  output logic [MONEY_W-1:0] result_amount,
  output logic               err_led
);

  state_t             state, state_nxt;
  logic [MONEY_W-1:0] total_nxt, result_nxt;
  logic [AMT_W-1:0]   count_nxt;
  logic               accept_nxt, reject_nxt, done_nxt, refund_nxt;
  logic               q_load, q_inc, q_clr, q_same, q_ripe;
  logic [AMT_W-1:0]   q_cap;
  logic [CNT_W-1:0]   q_cnt;
  logic [MONEY_W:0]   sum;
  logic               fits;

  atm_bill_qualifier #(.STABLE_CYCLES(STABLE_CYCLES)) u_qual (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (q_load),
    .inc    (q_inc),
    .clr    (q_clr),
    .amount (amount),
    .cap    (q_cap),
    .cnt    (q_cnt),
    .same   (q_same),
    .ripe   (q_ripe)
  );

  // One extra bit so an over-limit sum is caught instead of wrapping.
  assign sum  = {1'b0, total} + {{(MONEY_W + 1 - AMT_W){1'b0}}, q_cap};
  assign fits = (sum <= {1'b0, MAX_TOTAL}) && (bill_count < MAX_BILLS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      total         <= '0;
      bill_count    <= '0;
      result_amount <= '0;
      accept        <= 1'b0;
      reject        <= 1'b0;
      deposit_done  <= 1'b0;
      refund        <= 1'b0;
      err_led       <= 1'b0;
    end else begin
      state         <= state_nxt;
      total         <= total_nxt;
      bill_count    <= count_nxt;
      result_amount <= result_nxt;
      accept        <= accept_nxt;
      reject        <= reject_nxt;
      deposit_done  <= done_nxt;
      refund        <= refund_nxt;
      err_led       <= multi_err;
    end
  end

  always_comb begin
    state_nxt  = state;
    total_nxt  = total;
    count_nxt  = bill_count;
    result_nxt = result_amount;
    accept_nxt = 1'b0;
    reject_nxt = 1'b0;
    done_nxt   = 1'b0;
    refund_nxt = 1'b0;
    q_load     = 1'b0;
    q_inc      = 1'b0;
    q_clr      = 1'b0;

    // Cancel outranks confirm and any bill completing in the same cycle.
    if (cancel && state != SETTLE) begin
      result_nxt = total;
      refund_nxt = 1'b1;
      total_nxt  = '0;
      count_nxt  = '0;
      q_clr      = 1'b1;
      state_nxt  = SETTLE;
    end else begin
      case (state)
        IDLE: begin
          if (confirm && total != '0) begin
            result_nxt = total;
            done_nxt   = 1'b1;
            total_nxt  = '0;
            count_nxt  = '0;
            state_nxt  = SETTLE;
          end else if (amount != '0 && !multi_err) begin
            q_load    = 1'b1;
            state_nxt = QUAL;
          end
        end
        QUAL: begin
          if (amount == '0 || multi_err) begin
            q_clr     = 1'b1;
            state_nxt = IDLE;
          end else if (!q_same) begin
            q_load = 1'b1;
          end else if (q_ripe) begin
            q_clr     = 1'b1;
            state_nxt = WAIT_REL;
            if (fits) begin
              total_nxt  = sum[MONEY_W-1:0];
              count_nxt  = bill_count + AMT_W'(1);
              accept_nxt = 1'b1;
            end else begin
              reject_nxt = 1'b1;
            end
          end else begin
            q_inc = 1'b1;
          end
        end
        WAIT_REL: begin
          if (amount == '0 && !multi_err) state_nxt = IDLE;
        end
        SETTLE: begin
          if (!confirm && !cancel && amount == '0) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_deposit_accumulator.sv
// Directed bench for atm_deposit_accumulator with default parameters.
// Each step drives inputs 1ns after a rising edge and samples outputs there too.
module tb_atm_deposit_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  amount;
  logic        multi_err, confirm, cancel;
  logic [15:0] total, result_amount;
  logic [7:0]  bill_count;
  logic        accept, reject, deposit_done, refund, err_led;

  int errors = 0;
  int checks = 0;

  atm_deposit_accumulator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .amount        (amount),
    .multi_err     (multi_err),
    .confirm       (confirm),
    .cancel        (cancel),
    .total         (total),
    .bill_count    (bill_count),
    .accept        (accept),
    .reject        (reject),
    .deposit_done  (deposit_done),
    .refund        (refund),
    .result_amount (result_amount),
    .err_led       (err_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int nacc, output int first, output int nrej);
    nacc = 0; first = 0; nrej = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (accept) begin
        nacc++;
        if (first == 0) first = i;
      end
      if (reject) nrej++;
    end
  endtask

  // Present a bill for exactly the qualification window, then release it.
  task automatic bill(input logic [7:0] v, output int nacc, output int nrej);
    int a1, f1, r1, a2, f2, r2;
    amount = v;
    run(4, a1, f1, r1);
    amount = 8'd0;
    run(1, a2, f2, r2);
    nacc = a1 + a2;
    nrej = r1 + r2;
  endtask

  initial begin
    int na, fa, nr, sa, sr;
    rst_n = 1'b0; amount = 8'd0; multi_err = 1'b0; confirm = 1'b0; cancel = 1'b0;
    step(); step();
    chk("reset_total", total, 0);
    chk("reset_bill_count", bill_count, 0);
    chk("reset_result", result_amount, 0);
    chk("reset_pulses", {accept, reject, deposit_done, refund, err_led}, 0);
    rst_n = 1'b1;
    step();

    // Single bill held past the window is counted once, on edge 4.
    amount = 8'd20;
    run(6, na, fa, nr);
    chk("hold20_accepts", na, 1);
    chk("hold20_first_edge", fa, 4);
    chk("hold20_total", total, 20);
    chk("hold20_bill_count", bill_count, 1);
    amount = 8'd0;
    step();

    cancel = 1'b1;
    step();
    chk("cancel_idle_refund", refund, 1);
    chk("cancel_idle_result", result_amount, 20);
    chk("cancel_idle_total", total, 0);
    cancel = 1'b0;
    step();

    // Too-short pulse never qualifies.
    amount = 8'd50;
    run(2, na, fa, nr);
    amount = 8'd0;
    run(1, sa, fa, sr);
    chk("short50_accepts", na + sa, 0);
    chk("short50_total", total, 0);

    // Three bills then commit.
    sa = 0;
    bill(8'd100, na, nr); sa += na;
    bill(8'd5, na, nr);   sa += na;
    bill(8'd1, na, nr);   sa += na;
    chk("three_bills_accepts", sa, 3);
    chk("three_bills_total", total, 106);
    chk("three_bills_count", bill_count, 3);
    confirm = 1'b1;
    step();
    chk("confirm_done", deposit_done, 1);
    chk("confirm_result", result_amount, 106);
    chk("confirm_total", total, 0);
    chk("confirm_count", bill_count, 0);
    step();
    chk("confirm_held_once", deposit_done, 0);
    confirm = 1'b0;
    step();

    // Confirm on an empty session does nothing.
    confirm = 1'b1;
    step();
    chk("confirm_empty_done", deposit_done, 0);
    chk("confirm_empty_result", result_amount, 106);
    confirm = 1'b0;
    step();

    // Build 9950 = 39*255 + 5, then hit the total limit.
    sa = 0; sr = 0;
    for (int i = 0; i < 39; i++) begin
      bill(8'd255, na, nr); sa += na; sr += nr;
    end
    bill(8'd5, na, nr); sa += na; sr += nr;
    chk("fill_accepts", sa, 40);
    chk("fill_rejects", sr, 0);
    chk("fill_total", total, 9950);
    bill(8'd100, na, nr);
    chk("over_limit_reject", nr, 1);
    chk("over_limit_accept", na, 0);
    chk("over_limit_total", total, 9950);
    chk("over_limit_count", bill_count, 40);
    bill(8'd49, na, nr);
    chk("exact_limit_accept", na, 1);
    chk("exact_limit_total", total, 9999);
    cancel = 1'b1;
    step();
    chk("cancel_full_result", result_amount, 9999);
    cancel = 1'b0;
    step();

    // Cancel and confirm together while a bill is about to qualify.
    bill(8'd25, na, nr);
    chk("pre_cancel_total", total, 25);
    amount = 8'd10;
    run(3, na, fa, nr);
    cancel = 1'b1; confirm = 1'b1;
    step();
    chk("race_refund", refund, 1);
    chk("race_result", result_amount, 25);
    chk("race_accept", accept + na, 0);
    chk("race_done", deposit_done, 0);
    chk("race_total", total, 0);
    cancel = 1'b0; confirm = 1'b0; amount = 8'd0;
    step();

    // Decoder warning shows on err_led one cycle later.
    multi_err = 1'b1;
    step();
    chk("multi_err_led", err_led, 1);
    chk("multi_err_accept", accept, 0);
    multi_err = 1'b0;
    step();
    chk("multi_err_led_clear", err_led, 0);

    // Mid-session reset drops the total silently.
    bill(8'd20, na, nr);
    bill(8'd15, na, nr);
    chk("pre_reset_total", total, 35);
    rst_n = 1'b0;
    step();
    chk("reset_mid_total", total, 0);
    chk("reset_mid_refund", refund, 0);
    chk("reset_mid_count", bill_count, 0);
    chk("reset_mid_result", result_amount, 0);
    rst_n = 1'b1;
    step();

    cancel = 1'b1;
    step();
    chk("cancel_zero_refund", refund, 1);
    chk("cancel_zero_result", result_amount, 0);
    cancel = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/atm_deposit_accumulator.md
ATM_DEPOSIT_ACCUMULATOR -- requirements
Module: atm_deposit_accumulator

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples needed to accept a bill, legal range 2..15.
REQ-002 The block SHALL have parameter MAX_TOTAL, default 16'd9999: highest permitted session total in dollars.
REQ-003 The block SHALL have parameter MAX_BILLS, default 8'd50: highest permitted bills per session.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-007 The block SHALL have port amount, input, 8 bits: bill value from the bill decoder; 0 means no bill.
REQ-008 The block SHALL have port multi_err, input, 1 bit: decoder warning that more than one bill switch is up.
REQ-009 The block SHALL have port confirm, input, 1 bit: level request to commit the session total.
REQ-010 The block SHALL have port cancel, input, 1 bit: level request to refund the session total.
REQ-011 The block SHALL have port total, output, 16 bits: running session total in dollars.
REQ-012 The block SHALL have port bill_count, output, 8 bits: bills accepted this session.
REQ-013 The block SHALL have port accept, output, 1 bit: one-cycle pulse when a bill is added.
REQ-014 The block SHALL have port reject, output, 1 bit: one-cycle pulse when a qualified bill would exceed a limit.
REQ-015 The block SHALL have port deposit_done, output, 1 bit: one-cycle pulse when a commit occurs.
REQ-016 The block SHALL have port refund, output, 1 bit: one-cycle pulse when a refund occurs.
REQ-017 The block SHALL have port result_amount, output, 16 bits: value committed or refunded, held until the next commit or refund.
REQ-018 The block SHALL have port err_led, output, 1 bit: registered copy of multi_err, 1-cycle delay.

Function
REQ-019 The FSM SHALL use exactly four states: IDLE, QUAL, WAIT_REL and SETTLE.
REQ-020 In IDLE, when amount!=0 and multi_err=0, the FSM SHALL go to QUAL, capture amount, and set the sample count to 1.
REQ-021 In QUAL, each cycle with an unchanged amount and multi_err=0 SHALL increment the count.
REQ-022 In QUAL, a changed nonzero amount SHALL recapture amount and set the count to 1.
REQ-023 In QUAL, amount=0 or multi_err=1 SHALL clear the count and return the FSM to IDLE with no pulse.
REQ-024 When the count reaches STABLE_CYCLES and total+captured<=MAX_TOTAL and bill_count<MAX_BILLS, the block SHALL add the captured value to total, increment bill_count, pulse accept, and go to WAIT_REL.
REQ-025 When the count reaches STABLE_CYCLES and either limit would be exceeded, the block SHALL pulse reject, leave total and bill_count unchanged, and go to WAIT_REL.
REQ-026 Bill-acceptance latency SHALL be STABLE_CYCLES edges from the first valid sample; the new total and the accept pulse SHALL be visible in the same cycle.
REQ-027 WAIT_REL SHALL return to IDLE only after amount=0 and multi_err=0 are sampled, so a held switch is counted once.
REQ-028 Addition SHALL be done at 17-bit width for the limit compare, and total SHALL never wrap.
REQ-029 Confirm SHALL be honoured only in IDLE with total>0: result_amount<=total, deposit_done pulses, total and bill_count clear, then SETTLE.
REQ-030 Cancel SHALL be honoured in IDLE, QUAL and WAIT_REL: result_amount<=total, refund pulses, total, bill_count and the count clear, then SETTLE.
REQ-031 When cancel is honoured with total=0, refund SHALL still pulse with result_amount=0.
REQ-032 Cancel SHALL win when confirm and cancel are sampled in the same cycle.
REQ-033 Cancel SHALL win over a bill qualifying in the same cycle, and the bill SHALL be discarded.
REQ-034 SETTLE SHALL hold until confirm=0, cancel=0 and amount=0 are sampled, then go to IDLE; level requests SHALL therefore act once.
REQ-035 Confirm with total=0 SHALL be ignored and the FSM SHALL stay in IDLE.

Reset
REQ-036 While rst_n=0 at a rising edge, the FSM SHALL go to IDLE.
REQ-037 While rst_n=0 at a rising edge, total, bill_count, result_amount and the count SHALL clear to 0.
REQ-038 While rst_n=0 at a rising edge, accept, reject, deposit_done, refund and err_led SHALL clear to 0.
REQ-039 Reset mid-session SHALL discard the total with no refund pulse.

Structure
REQ-040 The state encoding, the 16-bit money width and the default limit constants SHALL live in shared package atm_pkg.
REQ-041 Stability qualification (capture register plus counter) SHALL be one sub-module, atm_bill_qualifier, and the FSM and arithmetic SHALL stay in the top module.

Verification
REQ-042 The bench SHALL check: amount=20 held 6 cycles, then 0 -> one accept in edge 4, total=20, bill_count=1.
REQ-043 The bench SHALL check: amount=50 held 2 cycles, then 0 -> no accept, total=0.
REQ-044 The bench SHALL check: bills 100, 5 and 1, then confirm -> deposit_done, result_amount=106, total=0.
REQ-045 The bench SHALL check: total=9950, then amount=100 qualified -> reject, total=9950.
REQ-046 The bench SHALL check: amount=10 in QUAL with cancel and confirm high together -> refund, result_amount equal to the prior total, no accept.
REQ-047 The bench SHALL check: multi_err=1 with amount=0 -> err_led=1 after 1 cycle and no accept; then rst_n=0 with total=35 -> total=0 and no refund.
